// File: rtl/ram_pkg.sv
// Shared types and elaboration helpers for the clocked single-port RAM.
package ram_pkg;

    typedef enum logic [0:0] {
        RAM_CLEAR,
        RAM_RUN
    } ram_state_t;

    function automatic bit read_latency_ok(input int unsigned lat);
        return (lat == 1) || (lat == 2);
    endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// Valid/data delay line appended after the array read register.
module ram_rd_pipe #(
    parameter int unsigned depth     = 1,
    parameter int unsigned data_bits = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [data_bits-1:0] in_data,
    output logic                 out_valid,
    output logic [data_bits-1:0] out_data
);

    if (depth == 0) begin : g_bypass
        logic unused_clk_rst;
        assign unused_clk_rst = clk & rst_n;
        assign out_valid      = in_valid;
        assign out_data       = in_data;
    end else begin : g_stages
        logic [depth-1:0]     valid_q, valid_d;
        logic [data_bits-1:0] data_q [depth];
        logic [data_bits-1:0] data_d [depth];

        // Data stages only load on a valid beat so the output holds its last value.
        always_comb begin
            valid_d[0] = in_valid;
            data_d[0]  = in_valid ? in_data : data_q[0];
            for (int i = 1; i < int'(depth); i++) begin
                valid_d[i] = valid_q[i-1];
                data_d[i]  = valid_q[i-1] ? data_q[i-1] : data_q[i];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= '0;
                for (int i = 0; i < int'(depth); i++) begin
                    data_q[i] <= '0;
                end
            end else begin
                valid_q <= valid_d;
                for (int i = 0; i < int'(depth); i++) begin
                    data_q[i] <= data_d[i];
                end
            end
        end

        assign out_valid = valid_q[depth-1];
        assign out_data  = data_q[depth-1];
    end

endmodule

// File: rtl/ram_sync.sv
// Clocked single-port RAM with valid/ready requests, 1- or 2-cycle read latency
// and a reset-time zeroing sweep.
module ram_sync
    import ram_pkg::*;
#(
    parameter int unsigned addr_bits      = 16,
    parameter int unsigned data_bits      = 8,
    parameter int unsigned read_latency   = 1,
    parameter bit          clear_on_reset = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [addr_bits-1:0] req_addr,
    input  logic [data_bits-1:0] req_wdata,
    output logic                 rsp_valid,
    output logic [data_bits-1:0] rsp_rdata,
    output logic                 busy
);

    localparam int unsigned Depth      = 2 ** addr_bits;
    localparam ram_state_t  ResetState = clear_on_reset ? RAM_CLEAR : RAM_RUN;

    if (!read_latency_ok(read_latency)) begin : g_bad_latency
        $error("ram_sync: read_latency must be 1 or 2");
    end

    logic [data_bits-1:0] mem [Depth];

    ram_state_t           state_q, state_d;
    logic [addr_bits:0]   cnt_q, cnt_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 rd_valid_q, rd_valid_d;
    logic [data_bits-1:0] rd_data_q, rd_data_d;

    logic                 accept;
    logic                 mem_we;
    logic [addr_bits-1:0] mem_waddr;
    logic [data_bits-1:0] mem_wdata;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == RAM_CLEAR) begin
            cnt_d = cnt_q + 1'b1;
            // Extra counter bit sets exactly after the last word is written.
            if (cnt_d[addr_bits]) begin
                state_d = RAM_RUN;
            end
        end
        ready_d = (state_d == RAM_RUN);
        busy_d  = (state_d == RAM_CLEAR);

        accept     = req_valid && ready_q;
        mem_we     = (state_q == RAM_CLEAR) || (accept && req_write);
        mem_waddr  = (state_q == RAM_CLEAR) ? cnt_q[addr_bits-1:0] : req_addr;
        mem_wdata  = (state_q == RAM_CLEAR) ? '0 : req_wdata;
        rd_valid_d = accept && !req_write;
        rd_data_d  = rd_valid_d ? mem[req_addr] : rd_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ResetState;
            cnt_q      <= '0;
            ready_q    <= 1'b0;
            busy_q     <= clear_on_reset;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    ram_rd_pipe #(
        .depth     (read_latency - 1),
        .data_bits (data_bits)
    ) u_rd_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (rd_valid_q),
        .in_data   (rd_data_q),
        .out_valid (rsp_valid),
        .out_data  (rsp_rdata)
    );

    assign req_ready = ready_q;
    assign busy      = busy_q;

endmodule
